// File: rtl/pmem_types_pkg.sv
// Shared sizes, FSM state encoding and beat-slicing helpers for the
// line-to-burst memory responder.
package pmem_types_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_WIDTH  = 64;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Extract beat idx of a line; beat 0 is the least significant 64 bits.
  function automatic logic [BEAT_WIDTH-1:0] beat_of(
    input logic [LINE_WIDTH-1:0] line,
    input logic [1:0]            idx
  );
    return line[int'(idx) * BEAT_WIDTH +: BEAT_WIDTH];
  endfunction

  // Replace beat idx of a line with a new 64-bit value.
  function automatic logic [LINE_WIDTH-1:0] put_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [1:0]            idx,
    input logic [BEAT_WIDTH-1:0] beat
  );
    logic [LINE_WIDTH-1:0] res;
    res = line;
    res[int'(idx) * BEAT_WIDTH +: BEAT_WIDTH] = beat;
    return res;
  endfunction

endpackage

// File: rtl/pmem_line_responder.sv
// Converts one 256-bit line request into a four-beat 64-bit burst to backing
// memory; all outputs are registered and the completion pulse lasts one cycle.
module pmem_line_responder
  import pmem_types_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  state_e                r_state;
  logic [1:0]            r_beat;
  logic [LINE_WIDTH-1:0] r_line;

  // The line offset bits never reach the backing memory.
  logic w_offset_unused;
  assign w_offset_unused = ^pmem_address[OFFSET_BITS-1:0];

  // Burst sequencer: request accept, beat counting, line capture and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= 2'd0;
      r_line      <= '0;
      pmem_rdata  <= '0;
      pmem_resp   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 32'd0;
      mem_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          pmem_resp <= 1'b0;
          // Write has priority when both requests are present.
          if (pmem_write) begin
            r_state     <= ST_WR_BURST;
            r_beat      <= 2'd0;
            r_line      <= pmem_wdata;
            mem_write   <= 1'b1;
            mem_read    <= 1'b0;
            mem_address <= {pmem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            mem_wdata   <= beat_of(pmem_wdata, 2'd0);
          end else if (pmem_read) begin
            r_state     <= ST_RD_BURST;
            r_beat      <= 2'd0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= {pmem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RD_BURST: begin
          if (mem_resp) begin
            r_line <= put_beat(r_line, r_beat, mem_rdata);
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_state    <= ST_DONE;
              mem_read   <= 1'b0;
              pmem_resp  <= 1'b1;
              pmem_rdata <= put_beat(r_line, r_beat, mem_rdata);
            end else begin
              r_state <= ST_RD_BURST;
            end
          end else begin
            r_state <= ST_RD_BURST;
          end
        end

        ST_WR_BURST: begin
          if (mem_resp) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_state   <= ST_DONE;
              mem_write <= 1'b0;
              pmem_resp <= 1'b1;
            end else begin
              r_state   <= ST_WR_BURST;
              mem_wdata <= beat_of(r_line, r_beat + 2'd1);
            end
          end else begin
            r_state <= ST_WR_BURST;
          end
        end

        ST_DONE: begin
          r_state   <= ST_IDLE;
          pmem_resp <= 1'b0;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_beat    <= 2'd0;
          pmem_resp <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomised bench: a line-addressed memory model answers the bursts and
// every cycle is checked against transaction-level expectations.
module tb_pmem_line_responder;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int total;
  int bad;
  logic [255:0] prev_rdata;
  logic [255:0] mem_model [logic [31:0]];

  pmem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_resp"}, {255'd0, pmem_resp}, 256'd0);
    check_eq({tag, "_rd"}, {255'd0, mem_read}, 256'd0);
    check_eq({tag, "_wr"}, {255'd0, mem_write}, 256'd0);
    check_eq({tag, "_rdata"}, pmem_rdata, prev_rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      mem_resp   = 1'($urandom);
      mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // One line transaction; abort_at>0 pulls reset after that many beats.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [255:0] wdata, input int stall, input int abort_at);
    logic [31:0]  a;
    logic [255:0] line;
    logic [255:0] got;
    int           beats;
    bit           done;
    bit           is_resp;
    a     = {addr[31:5], 5'd0};
    got   = '0;
    beats = 0;
    done  = 1'b0;
    if (wr) begin
      line = wdata;
    end else begin
      if (!mem_model.exists(a)) mem_model[a] = rand256();
      line = mem_model[a];
    end
    @(posedge clk); #1;
    pmem_write   = wr;
    pmem_read    = rd;
    pmem_address = addr;
    pmem_wdata   = wdata;
    mem_resp     = 1'($urandom);
    mem_rdata    = {$urandom, $urandom};
    @(negedge clk);
    check_quiet("accept");
    for (int c = 2; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (abort_at != 0 && beats == abort_at) begin
        rst        = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        #1;
        check_eq("abort_resp",  {255'd0, pmem_resp}, 256'd0);
        check_eq("abort_rd",    {255'd0, mem_read},  256'd0);
        check_eq("abort_wr",    {255'd0, mem_write}, 256'd0);
        check_eq("abort_addr",  {224'd0, mem_address}, 256'd0);
        check_eq("abort_wdata", {192'd0, mem_wdata}, 256'd0);
        check_eq("abort_rdata", pmem_rdata, 256'd0);
        @(posedge clk); #1;
        rst        = 1'b1;
        prev_rdata = '0;
        return;
      end
      pmem_address = $urandom;
      pmem_wdata   = rand256();
      if (beats < 4) begin
        case (stall)
          0:       is_resp = 1'b1;
          1:       is_resp = ((c - 1) % 3 == 0);
          default: is_resp = 1'($urandom);
        endcase
        mem_resp  = is_resp;
        mem_rdata = line[64*beats +: 64];
      end else begin
        is_resp   = 1'b0;
        mem_resp  = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end
      @(negedge clk);
      if (beats < 4) begin
        check_eq("burst_rd",    {255'd0, mem_read},  {255'd0, !wr});
        check_eq("burst_wr",    {255'd0, mem_write}, {255'd0, wr});
        check_eq("burst_addr",  {224'd0, mem_address}, {224'd0, a});
        check_eq("burst_resp",  {255'd0, pmem_resp}, 256'd0);
        check_eq("burst_rdata", pmem_rdata, prev_rdata);
        if (wr) check_eq("wbeat", {192'd0, mem_wdata}, {192'd0, line[64*beats +: 64]});
        if (is_resp) begin
          got[64*beats +: 64] = mem_wdata;
          beats++;
        end
      end else begin
        check_eq("done_resp", {255'd0, pmem_resp}, {255'd0, 1'b1});
        check_eq("done_rd",   {255'd0, mem_read},  256'd0);
        check_eq("done_wr",   {255'd0, mem_write}, 256'd0);
        if (!wr) check_eq("line", pmem_rdata, line);
        if (stall == 0) check_eq("latency", 256'(c), 256'd6);
        done = 1'b1;
      end
    end
    if (!done) check_eq("timeout", 256'd0, 256'd1);
    if (wr) begin
      check_eq("wline", got, wdata);
      mem_model[a] = got;
    end else begin
      prev_rdata = line;
    end
  endtask

  initial begin
    logic [31:0]  addr;
    logic [255:0] wd;
    int           kind;
    total        = 0;
    bad          = 0;
    prev_rdata   = '0;
    rst          = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = '0;
    mem_rdata    = 64'd0;
    mem_resp     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_resp",  {255'd0, pmem_resp}, 256'd0);
    check_eq("rst_rd",    {255'd0, mem_read},  256'd0);
    check_eq("rst_wr",    {255'd0, mem_write}, 256'd0);
    check_eq("rst_addr",  {224'd0, mem_address}, 256'd0);
    check_eq("rst_wdata", {192'd0, mem_wdata}, 256'd0);
    check_eq("rst_rdata", pmem_rdata, 256'd0);
    rst = 1'b1;
    idle(2);

    mem_model[32'h0000_1220] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b0, 1'b1, 32'h0000_1234, '0, 0, 0);
    idle(1);
    wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_txn(1'b1, 1'b0, 32'h0000_2040, wd, 0, 0);
    idle(1);
    run_txn(1'b0, 1'b1, 32'h0000_3000, '0, 1, 0);
    idle(2);
    run_txn(1'b1, 1'b1, 32'h0000_4060, rand256(), 0, 0);
    idle(1);
    run_txn(1'b0, 1'b1, 32'h0000_1220, '0, 0, 2);
    idle(3);
    run_txn(1'b0, 1'b1, 32'h0000_1220, '0, 0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_5000, rand256(), 2, 0);
    run_txn(1'b0, 1'b1, 32'h0000_501F, '0, 0, 0);
    idle(4);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom % 4);
      addr = 32'h0000_8000 + 32'(($urandom % 8) * 32) + 32'($urandom % 32);
      wd   = rand256();
      run_txn(kind == 1 || kind == 2, kind != 1, addr, wd, int'($urandom % 3), 0);
      if ($urandom % 2 == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- pmem_read  in  1  line read request; level, held until pmem_resp
- pmem_write  in  1  line write request; level, held until pmem_resp
- pmem_address  in  32  line address; bits [4:0] ignored
- pmem_wdata  in  256  line to write
- pmem_rdata  out  256  line read
- pmem_resp  out  1  one-cycle completion pulse
- mem_read  out  1  burst read to backing memory
- mem_write  out  1  burst write to backing memory
- mem_address  out  32  burst address, bits [4:0] = 0
- mem_wdata  out  64  write beat
- mem_rdata  in  64  read beat
- mem_resp  in  1  per-beat acknowledge

Function
REQ-003 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-004 IDLE: pmem_write=1 -> WR_BURST; else pmem_read=1 -> RD_BURST; write wins if both are set.
REQ-005 On accept, SHALL latch pmem_address with [4:0] cleared, and pmem_wdata for writes; later input changes SHALL be ignored until IDLE.
REQ-006 SHALL assert mem_read (RD_BURST) or mem_write (WR_BURST) from the cycle after accept through the cycle of the 4th mem_resp inclusive; mem_address SHALL be stable throughout.
REQ-007 SHALL keep a 2-bit beat counter, reset to 0 on accept, incremented on each mem_resp in a burst state; mem_resp with counter=3 SHALL go to DONE with the counter wrapped to 0.
REQ-008 Write beat k: mem_wdata = latched wdata[64k+63:64k], with beat 0 = bits [63:0].
REQ-009 Read beat k: mem_rdata captured into internal line bits [64k+63:64k]; pmem_rdata SHALL update only when the 4th beat is captured, and hold until the next read completes.
REQ-010 Stalls: cycles without mem_resp SHALL hold the state, counter and outputs.
REQ-011 DONE SHALL last exactly one cycle, with pmem_resp=1, then return to IDLE.
REQ-012 pmem_resp SHALL be 0 in all other states.
REQ-013 Requests SHALL be sampled only in IDLE; the requester drops its request the cycle after pmem_resp.
REQ-014 Minimum latency SHALL be 6 cycles: accept to pmem_resp, with mem_resp tied to 1.
REQ-015 mem_resp in IDLE or DONE SHALL be ignored.
REQ-016 A write followed by a read in consecutive transactions SHALL be supported with one IDLE cycle between them.

Reset
REQ-017 While rst=0: state=IDLE, counter=0, pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, pmem_rdata=0, latched line=0.
REQ-018 Reset mid-burst SHALL abort the burst immediately, discard partial data, and produce no pmem_resp.
REQ-019 After reset release, the first accept SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-020 Package pmem_types_pkg SHALL hold LINE_WIDTH=256, BEAT_WIDTH=64, BEATS=4, OFFSET_BITS=5, and the FSM state enum.
REQ-021 Single module with no sub-modules; the beat counter and line buffer SHALL be inline.

Verification
REQ-022 Read, mem_resp=1 continuously, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_address=0x0000_1220; pmem_resp at cycle 6; pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-023 Write, wdata = {0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..} -> mem_wdata beats AAAA, BBBB, CCCC, DDDD in order; mem_write high exactly until the 4th mem_resp; one pmem_resp pulse.
REQ-024 Read with mem_resp only every 3rd cycle -> outputs stable during stalls; pmem_resp follows the 4th ack by one cycle; the line matches.
REQ-025 pmem_read and pmem_write both set in IDLE -> WR_BURST taken; mem_read never asserts.
REQ-026 rst=0 after the 2nd read beat -> all outputs 0 at once; no pmem_resp; pmem_rdata=0; a next read completes normally.
REQ-027 Write then read back-to-back, modelling the requester dropping its request after pmem_resp -> exactly two pmem_resp pulses; no duplicate burst.
